// File: rtl/serial_add_if.sv
// Bundle of signals between a bit-serial adder controller, the datapath that
// requests additions from it, and the shared combinational full-adder cell.
//
// Signals:
//   start, op_a, op_b, cin  request side: start pulse plus operands/carry-in
//   busy, done              status: busy during RUN, done pulses one cycle
//   result, cout            registered sum and final carry-out
//   fa_a, fa_b, fa_c        bit pair and carry presented to the full-adder cell
//   fa_sum, fa_cout         sum and carry returned by the full-adder cell
//
// Modports:
//   master  environment side (requesting datapath together with the adder cell)
//   slave   the serial_add_ctrl controller
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             fa_a;
    logic             fa_b;
    logic             fa_c;
    logic             fa_sum;
    logic             fa_cout;

    modport master (
        output start, op_a, op_b, cin, fa_sum, fa_cout,
        input  busy, done, result, cout, fa_a, fa_b, fa_c
    );

    modport slave (
        input  start, op_a, op_b, cin, fa_sum, fa_cout,
        output busy, done, result, cout, fa_a, fa_b, fa_c
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller. Time-shares one external combinational
// full-adder cell to add two WIDTH-bit operands, LSB first, one bit per clock.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset; aborts any addition in progress
//   bus    serial_add_if.slave: start/op_a/op_b/cin request, busy/done status,
//          result/cout outputs, fa_a/fa_b/fa_c to the cell, fa_sum/fa_cout back
//
// A start accepted at edge k gives busy for cycles k+1..k+WIDTH and a one-cycle
// done in the following cycle; {cout,result} = op_a + op_b + cin.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    serial_add_if.slave  bus
);

    localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_a, fa_b, fa_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        fa_a    = 1'b0;
        fa_b    = 1'b0;
        fa_c    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new request exactly like IDLE so that
                // back-to-back additions lose only the done cycle.
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                fa_a    = a_q[0];
                fa_b    = b_q[0];
                fa_c    = carry_q;
                // Sum bits enter at the MSB; after WIDTH shifts bit 0 of the
                // operands has reached result[0].
                res_d   = {bus.fa_sum, res_q[WIDTH-1:1]};
                carry_d = bus.fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cout_d  = bus.fa_cout;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = res_q;
    assign bus.cout   = cout_q;
    assign bus.fa_a   = fa_a;
    assign bus.fa_b   = fa_b;
    assign bus.fa_c   = fa_c;

endmodule
